atetris_nvram_xfer: RTL

- Host-side initiator for the high-score/NVRAM secondary port. It is the opposite end of the NVRAM's hs_address/hs_data_in/hs_data_out/hs_write port.
- On request it pauses the game CPU and streams all NVRAM bytes out over a valid/ready byte stream (save). It can also accept a byte stream and write it into NVRAM (load).
- Sits at the core top level, between the host I/O bridge and the NVRAM hs port, and drives the core's pause input.

---
 rtl/atetris_nvram_xfer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/atetris_nvram_xfer.sv
// rtl/atetris_nvram_xfer.sv - NVRAM high-score port initiator: pauses the CPU and streams NVRAM out (save) or in (load).
// Optional trailing two's-complement checksum byte enabled by defining NVX_CHECKSUM_EN.
module atetris_nvram_xfer #(
    parameter int AW     = 9,
    parameter int SETTLE = 4
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          SAVE_REQ,
    input  logic          LOAD_REQ,
    output logic          BUSY,
    output logic          PAUSE_REQ,
    output logic          DONE,
    output logic          ERR,
    output logic [7:0]    TX_DT,
    output logic          TX_DV,
    input  logic          TX_RDY,
    input  logic [7:0]    RX_DT,
    input  logic          RX_DV,
    output logic          RX_RDY,
    output logic [AW-1:0] HS_AD,
    output logic [7:0]    HS_WD,
    output logic          HS_WE,
    input  logic [7:0]    HS_RD
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_RD_A, S_RD_D, S_TX, S_RX, S_WR, S_CK_TX, S_CK_RX, S_FIN
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST   = '1;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);

    state_t        state_q, state_d;
    logic          save_q, save_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    tx_dt_q, tx_dt_d;
    logic          tx_dv_q, tx_dv_d;
    logic [7:0]    wd_q, wd_d;
`ifdef NVX_CHECKSUM_EN
    logic          err_q, err_d;
    logic [7:0]    ck_total;
`endif

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            save_q  <= 1'b0;
            addr_q  <= '0;
            sum_q   <= 8'd0;
            cnt_q   <= 8'd0;
            tx_dt_q <= 8'd0;
            tx_dv_q <= 1'b0;
            wd_q    <= 8'd0;
`ifdef NVX_CHECKSUM_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            save_q  <= save_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            tx_dt_q <= tx_dt_d;
            tx_dv_q <= tx_dv_d;
            wd_q    <= wd_d;
`ifdef NVX_CHECKSUM_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        save_d  = save_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        tx_dt_d = tx_dt_q;
        tx_dv_d = tx_dv_q;
        wd_d    = wd_q;
`ifdef NVX_CHECKSUM_EN
        err_d    = err_q;
        ck_total = sum_q + RX_DT;
`endif
        case (state_q)
            S_IDLE: begin
                if (SAVE_REQ || LOAD_REQ) begin
                    // Save has priority when both requests arrive together.
                    save_d  = SAVE_REQ;
                    addr_d  = '0;
                    sum_d   = 8'd0;
                    cnt_d   = 8'd0;
                    state_d = S_SETTLE;
`ifdef NVX_CHECKSUM_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = save_q ? S_RD_A : S_RX;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RD_A: state_d = S_RD_D;
            S_RD_D: begin
                tx_dt_d = HS_RD;
                tx_dv_d = 1'b1;
                sum_d   = sum_q + HS_RD;
                state_d = S_TX;
            end
            S_TX: begin
                if (TX_RDY) begin
                    tx_dv_d = 1'b0;
                    if (addr_q == ADDR_LAST) begin
`ifdef NVX_CHECKSUM_EN
                        tx_dt_d = ~sum_q + 8'd1;
                        tx_dv_d = 1'b1;
                        state_d = S_CK_TX;
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = S_RD_A;
                    end
                end
            end
            S_RX: begin
                if (RX_DV) begin
                    wd_d    = RX_DT;
                    sum_d   = sum_q + RX_DT;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (addr_q == ADDR_LAST) begin
`ifdef NVX_CHECKSUM_EN
                    state_d = S_CK_RX;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = S_RX;
                end
            end
`ifdef NVX_CHECKSUM_EN
            S_CK_TX: begin
                if (TX_RDY) begin
                    tx_dv_d = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_CK_RX: begin
                // Checksum byte is never written; data bytes are already committed.
                if (RX_DV) begin
                    err_d   = (ck_total != 8'd0);
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign PAUSE_REQ = BUSY;
    assign DONE      = (state_q == S_FIN);
    assign TX_DT     = tx_dt_q;
    assign TX_DV     = tx_dv_q;
    assign HS_AD     = addr_q;
    assign HS_WD     = wd_q;
    assign HS_WE     = (state_q == S_WR);
`ifdef NVX_CHECKSUM_EN
    assign RX_RDY    = (state_q == S_RX) || (state_q == S_CK_RX);
    assign ERR       = err_q;
`else
    assign RX_RDY    = (state_q == S_RX);
    assign ERR       = 1'b0;
`endif

endmodule
